mult_job_dispatcher: RTL and testbench
======================================

// Module: mult_job_dispatcher
// PURPOSE
//  Upstream feeder/collector for the N-bit sequential multiplier (ports a_in/b_in/start/finish/out).
//  - Accepts operand pairs on a valid/ready input and buffers them in a DEPTH-entry FIFO.
//  - Issues one job at a time to the multiplier, captures `out` when `finish` rises,
//    and presents the product on a valid/ready result port.
//  - Makes the multi-cycle multiplier look like a streaming unit to the rest of the datapath.
// PARAMETERS
//  N        5      operand width; product width is 2*N
//  DEPTH    4      operand FIFO entries; power of 2, >=2
//  TIMEOUT  2*N+4  watchdog limit in cycles (used only with MUL_TIMEOUT_EN)
// PORTS
//  clk          in   1    system clock, rising edge
//  reset        in   1    asynchronous, active-high
//  in_valid     in   1    operand pair valid
//  in_ready     out  1    FIFO not full
//  in_a         in   N    operand A
//  in_b         in   N    operand B
//  mul_a        out  N    to multiplier a_in; held stable while mul_start=1
//  mul_b        out  N    to multiplier b_in; held stable while mul_start=1
//  mul_start    out  1    to multiplier start; level, held until finish
//  mul_product  in   2N   from multiplier out
//  mul_finish   in   1    from multiplier finish
//  res_valid    out  1    result valid
//  res_ready    in   1    result consumer ready
//  res_product  out  2N   captured product
//  busy         out  1    FIFO non-empty or FSM not IDLE
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; FIFO emptied; all outputs 0 except in_ready=1.
//  FIFO: push when in_valid&in_ready; pop on IDLE->ISSUE. Full => in_ready=0.
//    Push and pop in the same cycle are both allowed; count is unchanged.
//    Pointers are log2(DEPTH) bits and wrap modulo DEPTH; an extra count bit distinguishes full/empty.
//  FSM:
//   IDLE    : FIFO non-empty & mul_finish=0 -> pop head into mul_a/mul_b, go ISSUE.
//             mul_start=0 in IDLE.
//   ISSUE   : mul_start=1. When mul_finish=1: capture mul_product into res_product,
//             res_valid<=1, go HOLD. Capture occurs the same edge finish is sampled high.
//   HOLD    : mul_start=0 (multiplier re-arms on start low); res_valid=1.
//             res_ready=1 -> res_valid<=0, go REARM.
//   REARM   : wait mul_finish=0, then go IDLE. Guarantees >=1 low-start cycle between jobs
//             and no stale finish.
//  Latency: in_valid to mul_start high >=2 cycles (FIFO write, then IDLE pop).
//    Result appears 1 cycle after finish is sampled.
//  res_product is held stable while res_valid=1 and res_ready=0. No new job issues until
//    the result is accepted (one job in flight, no result buffering).
//  Width: res_product = mul_product, 2N bits; no truncation; no dispatcher arithmetic.
//  Reset mid-job: mul_start drops asynchronously; the in-flight job and FIFO contents are
//    discarded; no result is produced.
// CONFIGURATION
//  MUL_TIMEOUT_EN defined:
//   - adds output `res_err` (1b) and a cycle counter in ISSUE.
//   - If mul_finish is not seen within TIMEOUT cycles: res_product<=0, res_err<=1,
//     res_valid<=1, go HOLD.
//   - res_err clears when the result is accepted.
//  MUL_TIMEOUT_EN undefined: no counter and no res_err port; ISSUE waits indefinitely.
// TESTING (N=5, DEPTH=4; bench multiplier model: finish N cycles after start)
//  1 reset=1 for 2 cycles, then push a=26,b=30 -> mul_start rises;
//    res_valid with res_product=780; busy=0 after accept.
//  2 back-to-back pushes (26,30),(13,13), res_ready=1 -> results 780 then 169 in order;
//    mul_start low >=1 cycle between the two jobs.
//  3 res_ready=0, push 5 pairs -> in_ready=0 after FIFO full (4 buffered + 1 in flight);
//    first result held stable; release -> all 5 products in order, incl. 31*31=961.
//  4 assert reset while in ISSUE -> mul_start=0, res_valid=0, in_ready=1 immediately;
//    no result emitted after release.
//  5 push and pop in the same cycle at count=3 -> count stays 3; pointer wrap past
//    entry 3 keeps data order intact.
//  6 [MUL_TIMEOUT_EN] model never asserts finish -> after TIMEOUT=14 cycles:
//    res_valid=1, res_err=1, res_product=0.

Source files
------------

// File: rtl/mult_job_dispatcher.sv
// mult_job_dispatcher
//   Front end for a sequential multiplier. Operand pairs are buffered in a
//   DEPTH-entry FIFO and issued one at a time over a level start/finish
//   handshake. Each product is held on a valid/ready result port until it is
//   accepted. At most one job is in flight and results are not buffered.
//
//   Optional feature macro: MUL_TIMEOUT_EN
//     Adds the res_err output and an ISSUE watchdog. If finish does not arrive
//     within TIMEOUT cycles, the block returns a zero product with res_err=1.
//
// Ports
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    operand input handshake; in_ready = FIFO not full
//   in_a, in_b           operands, N bits each
//   mul_a, mul_b         operands to the multiplier, stable while mul_start=1
//   mul_start            level start; held high until finish
//   mul_product          2N-bit product from the multiplier
//   mul_finish           multiplier done
//   res_valid/res_ready  result handshake
//   res_product          captured 2N-bit product
//   res_err              (MUL_TIMEOUT_EN only) result produced by the watchdog
//   busy                 FIFO non-empty or a job/result still pending
module mult_job_dispatcher #(
   parameter int N       = 5,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 2*N+4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_a,
   input  logic [N-1:0]   in_b,
   output logic [N-1:0]   mul_a,
   output logic [N-1:0]   mul_b,
   output logic           mul_start,
   input  logic [2*N-1:0] mul_product,
   input  logic           mul_finish,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [2*N-1:0] res_product,
`ifdef MUL_TIMEOUT_EN
   output logic           res_err,
`endif
   output logic           busy
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [N-1:0] a;
      logic [N-1:0] b;
   } job_t;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_REARM} state_t;

   state_t         state_q, state_d;
   job_t           mem_q [DEPTH];
   job_t           mem_d [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic [N-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic [2*N-1:0] res_product_q, res_product_d;
   logic           fifo_empty, fifo_full, push, pop, job_timeout;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == (AW+1)'(DEPTH));
   assign push       = in_valid && !fifo_full;
   // A finish still high from the previous job blocks a new issue.
   assign pop        = (state_q == S_IDLE) && !fifo_empty && !mul_finish;

`ifdef MUL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT+1);
   logic [TW-1:0] tmr_q, tmr_d;
   logic          res_err_q, res_err_d;

   // tmr_q counts ISSUE cycles from 0, so the watchdog fires on the
   // TIMEOUT-th cycle spent waiting for finish.
   always_comb begin
      tmr_d       = (state_q == S_ISSUE) ? tmr_q + 1'b1 : '0;
      job_timeout = (state_q == S_ISSUE) && !mul_finish && (tmr_q == TW'(TIMEOUT-1));
      res_err_d   = res_err_q;
      if (job_timeout)
         res_err_d = 1'b1;
      else if (state_q == S_HOLD && res_ready)
         res_err_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmr_q     <= '0;
         res_err_q <= 1'b0;
      end else begin
         tmr_q     <= tmr_d;
         res_err_q <= res_err_d;
      end
   end

   assign res_err = res_err_q;
`else
   assign job_timeout = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pop)                       state_d = S_ISSUE;
         S_ISSUE: if (mul_finish || job_timeout) state_d = S_HOLD;
         S_HOLD:  if (res_ready)                 state_d = S_REARM;
         S_REARM: if (!mul_finish)               state_d = S_IDLE;
         default:                                state_d = S_IDLE;
      endcase
   end

   // FSM outputs. Because these are decoded from state_q, mul_start and
   // res_valid fall as soon as reset is asserted.
   always_comb begin
      mul_start = (state_q == S_ISSUE);
      res_valid = (state_q == S_HOLD);
      in_ready  = !fifo_full;
      busy      = !fifo_empty || (state_q != S_IDLE);
   end

   // FIFO and datapath
   always_comb begin
      mem_d         = mem_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      mul_a_d       = mul_a_q;
      mul_b_d       = mul_b_q;
      res_product_d = res_product_q;
      if (push) begin
         mem_d[wr_ptr_q] = job_t'({in_a, in_b});
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         mul_a_d  = mem_q[rd_ptr_q].a;
         mul_b_d  = mem_q[rd_ptr_q].b;
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push)
         count_d = count_q - 1'b1;
      if (state_q == S_ISSUE && mul_finish)
         res_product_d = mul_product;
      else if (job_timeout)
         res_product_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         mul_a_q       <= '0;
         mul_b_q       <= '0;
         res_product_q <= '0;
      end else begin
         mem_q         <= mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         mul_a_q       <= mul_a_d;
         mul_b_q       <= mul_b_d;
         res_product_q <= res_product_d;
      end
   end

   assign mul_a       = mul_a_q;
   assign mul_b       = mul_b_q;
   assign res_product = res_product_q;

endmodule

// File: tb/tb_mult_job_dispatcher.sv
module tb_mult_job_dispatcher;
   localparam int N       = 5;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 2*N+4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [N-1:0]   in_a = '0, in_b = '0;
   logic [N-1:0]   mul_a, mul_b;
   logic           mul_start;
   logic [2*N-1:0] mul_product;
   logic           mul_finish;
   logic           res_valid;
   logic           res_ready = 1'b0;
   logic [2*N-1:0] res_product;
   logic           busy;
`ifdef MUL_TIMEOUT_EN
   logic           res_err;
   bit             expect_err = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   bit mul_en = 1'b1;

   always #5 clk = ~clk;

   mult_job_dispatcher #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
      .mul_product(mul_product), .mul_finish(mul_finish),
      .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
`ifdef MUL_TIMEOUT_EN
      .res_err(res_err),
`endif
      .busy(busy)
   );

   function automatic logic [2*N-1:0] prod(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [2*N-1:0] wa, wb;
      wa = {{N{1'b0}}, a};
      wb = {{N{1'b0}}, b};
      return wa * wb;
   endfunction

   // Multiplier model: finish N cycles after start, drops when start goes low.
   int mcnt;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mcnt <= 0; mul_finish <= 1'b0; mul_product <= '0;
      end else if (!mul_start) begin
         mcnt <= 0; mul_finish <= 1'b0;
      end else if (!mul_finish && mul_en) begin
         if (mcnt == N-1) begin
            mul_finish  <= 1'b1;
            mul_product <= prod(mul_a, mul_b);
         end else begin
            mcnt <= mcnt + 1;
         end
      end
   end

   // Scoreboard: pending operand queue and expected results, in order.
   logic [N-1:0]   pa_q[$], pb_q[$];
   logic [2*N-1:0] exp_q[$], got_q[$];
   logic [N-1:0]   cur_a, cur_b, ea, eb;
   logic [2*N-1:0] held, ep;
   bit             prev_start = 1'b0, prev_hold = 1'b0;
   int             n_rise = 0, n_acc = 0;

   always @(negedge clk) begin
      if (reset) begin
         pa_q.delete(); pb_q.delete(); exp_q.delete();
         prev_start = 1'b0; prev_hold = 1'b0;
      end else begin
         if (mul_start && !prev_start) begin
            n_rise++;
            checks++;
            if (pa_q.size() == 0) begin
               errors++;
               $display("FAIL issue_without_job: mul_start rose with no pending operands");
            end else begin
               ea = pa_q.pop_front(); eb = pb_q.pop_front();
               if (mul_a !== ea || mul_b !== eb) begin
                  errors++;
                  $display("FAIL issue_operands: got a=%0d b=%0d, expected a=%0d b=%0d", mul_a, mul_b, ea, eb);
               end
               exp_q.push_back(prod(ea, eb));
            end
            cur_a = mul_a; cur_b = mul_b;
         end else if (mul_start) begin
            checks++;
            if (mul_a !== cur_a || mul_b !== cur_b) begin
               errors++;
               $display("FAIL operand_hold: a=%0d b=%0d changed from a=%0d b=%0d", mul_a, mul_b, cur_a, cur_b);
            end
         end
         checks++;
         if (in_ready !== (pa_q.size() < DEPTH)) begin
            errors++;
            $display("FAIL in_ready: got %b with %0d buffered, expected %b", in_ready, pa_q.size(), pa_q.size() < DEPTH);
         end
         if (prev_hold) begin
            checks++;
            if (res_valid !== 1'b1 || res_product !== held) begin
               errors++;
               $display("FAIL res_hold: valid=%b product=%0d, expected valid=1 product=%0d", res_valid, res_product, held);
            end
         end
         if (res_valid && res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result: product=%0d with no job outstanding", res_product);
            end else begin
               ep = exp_q.pop_front();
`ifdef MUL_TIMEOUT_EN
               if (expect_err) ep = '0;
               if (res_err !== expect_err) begin
                  errors++;
                  $display("FAIL res_err: got %b expected %b", res_err, expect_err);
               end
`endif
               if (res_product !== ep) begin
                  errors++;
                  $display("FAIL result_value: got %0d expected %0d", res_product, ep);
               end
            end
            got_q.push_back(res_product);
            n_acc++;
         end
         prev_hold = res_valid && !res_ready;
         held      = res_product;
         if (in_valid && in_ready) begin
            pa_q.push_back(in_a); pb_q.push_back(in_b);
         end
         prev_start = mul_start;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
      int t = 0;
      in_a = a; in_b = b; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 300) begin @(negedge clk); t++; end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL push_timeout: in_ready stayed 0, required 1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_acc(input int target);
      int t = 0;
      while (n_acc < target && t < 800) begin tick(); t++; end
      checks++;
      if (n_acc < target) begin
         errors++;
         $display("FAIL result_wait: accepted %0d, required %0d", n_acc, target);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
      checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL rst_mul_start: got %b expected 0", mul_start); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b expected 0", res_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (res_product !== '0 || mul_a !== '0 || mul_b !== '0) begin
         errors++; $display("FAIL rst_data: product=%0d a=%0d b=%0d expected 0", res_product, mul_a, mul_b);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int t = 0;
      int n0 = n_acc;
      res_ready = 1'b1;
      push(5'd26, 5'd30);
      checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL start_latency: mul_start=%b at push edge, expected 0", mul_start); end
      while (!res_valid && t < 50) begin tick(); t++; end
      checks++; if (res_valid !== 1'b1 || res_product !== 10'd780) begin
         errors++; $display("FAIL basic_product: valid=%b product=%0d expected valid=1 product=780", res_valid, res_product);
      end
      t = 0;
      while (busy && t < 6) begin tick(); t++; end
      checks++; if (busy !== 1'b0 || n_acc != n0 + 1) begin
         errors++; $display("FAIL basic_done: busy=%b accepted=%0d expected busy=0 accepted=%0d", busy, n_acc - n0, 1);
      end
   endtask

   task automatic test_back_to_back();
      int g = got_q.size();
      int n0 = n_acc;
      int r0 = n_rise;
      res_ready = 1'b1;
      push(5'd26, 5'd30);
      push(5'd13, 5'd13);
      wait_acc(n0 + 2);
      checks++;
      if (got_q.size() < g + 2 || got_q[g] !== 10'd780 || got_q[g+1] !== 10'd169) begin
         errors++; $display("FAIL b2b_order: results %0d, expected 780 then 169", got_q.size() - g);
      end
      checks++; if (n_rise - r0 != 2) begin errors++; $display("FAIL b2b_starts: got %0d start pulses expected 2", n_rise - r0); end
   endtask

   task automatic test_full();
      logic [N-1:0] a [5];
      logic [N-1:0] b [5];
      int g = got_q.size();
      int n0 = n_acc;
      for (int i = 0; i < 5; i++) begin
         a[i] = N'($urandom_range(0, 31)); b[i] = N'($urandom_range(0, 31));
      end
      a[2] = 5'd31; b[2] = 5'd31;
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(a[i], b[i]);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
      repeat (20) tick();
      checks++; if (res_valid !== 1'b1 || res_product !== prod(a[0], b[0])) begin
         errors++; $display("FAIL full_hold: valid=%b product=%0d expected valid=1 product=%0d", res_valid, res_product, prod(a[0], b[0]));
      end
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL full_stall: in_ready=%b busy=%b expected 0 and 1", in_ready, busy);
      end
      res_ready = 1'b1;
      wait_acc(n0 + 5);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (got_q.size() <= g + i || got_q[g+i] !== prod(a[i], b[i])) begin
            errors++; $display("FAIL full_result%0d: expected %0d", i, prod(a[i], b[i]));
         end
      end
      checks++; if (got_q.size() <= g + 2 || got_q[g+2] !== 10'd961) begin
         errors++; $display("FAIL full_961: expected 961 as third result");
      end
   endtask

   task automatic test_reset_mid();
      int t = 0;
      int n0, r0;
      res_ready = 1'b1;
      push(N'($urandom_range(0, 31)), N'($urandom_range(0, 31)));
      push(N'($urandom_range(0, 31)), N'($urandom_range(0, 31)));
      tick();
      checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL mid_setup: mul_start=%b expected 1", mul_start); end
      #2 reset = 1'b1;
      #1;
      checks++; if (mul_start !== 1'b0 || res_valid !== 1'b0) begin
         errors++; $display("FAIL mid_outputs: mul_start=%b res_valid=%b expected 0 0", mul_start, res_valid);
      end
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_fifo: in_ready=%b busy=%b expected 1 0", in_ready, busy);
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      n0 = n_acc; r0 = n_rise;
      while (t < 4*N) begin
         tick(); t++;
         if (res_valid) begin
            checks++; errors++;
            $display("FAIL mid_stale: res_valid=1 after reset, expected 0");
         end
      end
      checks++; if (n_acc != n0 || n_rise != r0 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_silent: results=%0d starts=%0d busy=%b expected 0 0 0", n_acc - n0, n_rise - r0, busy);
      end
   endtask

   task automatic test_same_cycle();
      logic [N-1:0] a [6];
      logic [N-1:0] b [6];
      int t = 0;
      int g = got_q.size();
      int n0 = n_acc;
      for (int i = 0; i < 6; i++) begin
         a[i] = N'($urandom_range(0, 31)); b[i] = N'($urandom_range(0, 31));
      end
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(a[i], b[i]);
      while (!res_valid && t < 50) begin tick(); t++; end
      repeat (3) tick();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      tick();
      checks++; if (mul_start !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL sc_idle: mul_start=%b in_ready=%b expected 0 1", mul_start, in_ready);
      end
      in_a = a[4]; in_b = b[4]; in_valid = 1'b1;
      tick();
      checks++; if (mul_start !== 1'b1 || in_ready !== 1'b1) begin
         errors++; $display("FAIL sc_pushpop: mul_start=%b in_ready=%b expected 1 1", mul_start, in_ready);
      end
      in_a = a[5]; in_b = b[5];
      tick();
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sc_count: in_ready=%b expected 0", in_ready); end
      res_ready = 1'b1;
      wait_acc(n0 + 6);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got_q.size() <= g + i || got_q[g+i] !== prod(a[i], b[i])) begin
            errors++; $display("FAIL sc_result%0d: expected %0d", i, prod(a[i], b[i]));
         end
      end
   endtask

   bit rnd_done;
   task automatic test_random();
      int n0 = n_acc;
      int r0 = n_rise;
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 3)) tick();
               push(N'($urandom), N'($urandom));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               res_ready = ($urandom_range(0, 3) != 0);
               tick();
            end
         end
      join
      res_ready = 1'b1;
      wait_acc(n0 + 40);
      checks++; if (n_rise - r0 != 40) begin errors++; $display("FAIL rnd_starts: got %0d expected 40", n_rise - r0); end
   endtask

`ifdef MUL_TIMEOUT_EN
   task automatic test_timeout();
      int t = 0;
      int cnt = 0;
      mul_en = 1'b0; expect_err = 1'b1; res_ready = 1'b0;
      push(N'($urandom_range(1, 31)), N'($urandom_range(1, 31)));
      while (!mul_start && t < 10) begin tick(); t++; end
      while (mul_start && cnt < 100) begin tick(); cnt++; end
      checks++; if (cnt != TIMEOUT) begin errors++; $display("FAIL to_cycles: got %0d expected %0d", cnt, TIMEOUT); end
      checks++; if (res_valid !== 1'b1 || res_err !== 1'b1 || res_product !== '0) begin
         errors++; $display("FAIL to_result: valid=%b err=%b product=%0d expected 1 1 0", res_valid, res_err, res_product);
      end
      res_ready = 1'b1;
      tick();
      checks++; if (res_err !== 1'b0 || res_valid !== 1'b0) begin
         errors++; $display("FAIL to_clear: err=%b valid=%b expected 0 0", res_err, res_valid);
      end
      expect_err = 1'b0; mul_en = 1'b1;
      repeat (3) tick();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_full();
      test_reset_mid();
      test_same_cycle();
      test_random();
`ifdef MUL_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1, "watchdog");
   end
endmodule
